// File: rtl/rst_sequencer.sv
`timescale 1ns/1ps
// Reset sequencer: synchronises and debounces the button and PLL lock, then releases
// NCH reset domains in index order. Define RSTSEQ_WDOG_EN to add the RUN-state watchdog.
module rst_sequencer #(
  parameter int NCH       = 4,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 8,
  parameter int DEB_CYC   = 4,
  parameter int WDOG_CYC  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_n,
  input  logic                 pll_locked,
  input  logic                 wdog_kick,
  output logic [NCH-1:0]       rst_out,
  output logic                 ready,
  output logic [$clog2(NCH):0] released,
  output logic [1:0]           cause
);
  localparam int REL_W   = $clog2(NCH) + 1;
  localparam int CNT_MAX = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [REL_W-1:0] REL_ALL    = REL_W'(NCH);

  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;

  typedef enum logic [1:0] {HOLD, STAGE, RUN} stateT;

  logic [1:0]       btnSync, lockSync;
  logic             btnS, lockS;
  logic             pressReg;
  logic [DEB_W-1:0] debCntReg;

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [REL_W-1:0] releasedReg, releasedNext;
  logic [1:0]       causeReg, causeNext;
  logic [NCH-1:0]   rstOutReg, rstOutNext;
  logic             readyReg, readyNext;
  logic             abort;

  // Button chain presets to idle (high) so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnSync  <= 2'b11;
      lockSync <= 2'b00;
    end else begin
      btnSync  <= {btnSync[0], btn_n};
      lockSync <= {lockSync[0], pll_locked};
    end
  end

  assign btnS  = btnSync[1];
  assign lockS = lockSync[1];

  // A sample disagrees with the debounced state when btnS equals pressReg (press = button low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressReg  <= 1'b0;
      debCntReg <= '0;
    end else if (btnS == pressReg) begin
      if (debCntReg == DEB_LAST) begin
        pressReg  <= ~pressReg;
        debCntReg <= '0;
      end else begin
        debCntReg <= debCntReg + 1'b1;
      end
    end else begin
      debCntReg <= '0;
    end
  end

  assign abort = !lockS || pressReg;

`ifdef RSTSEQ_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  localparam logic [1:0] CAUSE_WDOG = 2'b11;

  logic [WDOG_W-1:0] wdogReg, wdogNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdogReg <= '0;
    else     wdogReg <= wdogNext;
  end
`else
  logic unusedWdog;
  assign unusedWdog = wdog_kick ^ (WDOG_CYC == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= HOLD;
      cntReg      <= '0;
      releasedReg <= '0;
      causeReg    <= '0;
      rstOutReg   <= '1;
      readyReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      releasedReg <= releasedNext;
      causeReg    <= causeNext;
      rstOutReg   <= rstOutNext;
      readyReg    <= readyNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    releasedNext = releasedReg;
    causeNext    = causeReg;
`ifdef RSTSEQ_WDOG_EN
    wdogNext     = '0;
`endif
    // Lock loss outranks the button; aborting in HOLD only restarts the stability count.
    if (stateReg != HOLD && abort) begin
      stateNext    = HOLD;
      cntNext      = '0;
      releasedNext = '0;
      causeNext    = lockS ? CAUSE_BTN : CAUSE_LOCK;
    end else begin
      case (stateReg)
        HOLD: begin
          if (abort) begin
            cntNext = '0;
          end else if (cntReg == HOLD_LAST) begin
            stateNext    = STAGE;
            cntNext      = '0;
            releasedNext = REL_W'(1);
          end else begin
            cntNext = cntReg + 1'b1;
          end
        end
        STAGE: begin
          if (cntReg == STAGE_LAST) begin
            cntNext = '0;
            if (releasedReg == REL_ALL) stateNext = RUN;
            else                        releasedNext = releasedReg + 1'b1;
          end else begin
            cntNext = cntReg + 1'b1;
          end
        end
        RUN: begin
`ifdef RSTSEQ_WDOG_EN
          if (!wdog_kick) begin
            if (wdogReg == WDOG_LAST) begin
              stateNext    = HOLD;
              releasedNext = '0;
              causeNext    = CAUSE_WDOG;
            end else begin
              wdogNext = wdogReg + 1'b1;
            end
          end
`endif
        end
        default: stateNext = HOLD;
      endcase
    end
  end

  always_comb begin
    readyNext = (stateNext == RUN);
  end

  // Thermometer decode of the next release count keeps every domain reset glitch-free.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gRstBit
      assign rstOutNext[gi] = (releasedNext <= REL_W'(gi));
    end
  endgenerate

  assign rst_out  = rstOutReg;
  assign ready    = readyReg;
  assign released = releasedReg;
  assign cause    = causeReg;

endmodule
